// File: rtl/fft_control.sv
// In-place radix-2 FFT sequencer: per-level butterfly read addressing,
// twiddle addressing and one-cycle-delayed write-back addressing.
module fft_control #(
  parameter int N_2 = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [3:0]     level,
  output logic           re,
  output logic [N_2-1:0] adrA,
  output logic [N_2-1:0] adrB,
  output logic [N_2-2:0] twiddleadr,
  output logic           we,
  output logic [N_2-1:0] wadrA,
  output logic [N_2-1:0] wadrB
);

  localparam int TW = N_2 - 1;
  localparam logic [TW-1:0] JMAX = {TW{1'b1}};
  localparam logic [3:0] LMAX = 4'(N_2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    level_d;
  logic [TW-1:0] j_q;
  logic [TW-1:0] j_d;
  logic [TW-1:0] tmask;
  logic          run;

  function automatic logic [N_2-1:0] rotl(
    input logic [N_2-1:0] x,
    input logic [3:0]     s
  );
    logic [N_2-1:0] r;
    r = x;
    for (int k = 0; k < 15; k++) begin
      if (k < int'(s)) begin
        r = {r[N_2-2:0], r[N_2-1]};
      end
    end
    return r;
  endfunction

  // state, stage index and butterfly counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      level   <= level_d;
      j_q     <= j_d;
    end
  end

  // next-state: j sweeps a level, one flush bubble between levels
  always_comb begin
    state_d = state_q;
    level_d = level;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          level_d = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (j_q == JMAX) begin
          state_d = FLUSH;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      FLUSH: begin
        if (level == LMAX) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          level_d = level + 4'd1;
          j_d     = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // read-side addressing, forced to zero outside RUN
  always_comb begin
    run        = (state_q == RUN);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    re         = run;
    tmask      = JMAX << (N_2 - 1 - int'(level));
    adrA       = '0;
    adrB       = '0;
    twiddleadr = '0;
    if (run) begin
      adrA       = rotl({j_q, 1'b0}, level);
      adrB       = rotl({j_q, 1'b1}, level);
      twiddleadr = j_q & tmask;
    end
  end

  // write-back trails the read by the RAM/ROM latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we    <= 1'b0;
      wadrA <= '0;
      wadrB <= '0;
    end else begin
      we    <= re;
      wadrA <= adrA;
      wadrB <= adrB;
    end
  end

endmodule
